// File: rtl/seg7_capture.sv
// Observes a four-digit active-low seven-segment display, filters transient patterns
// and presents each newly stable display value, decoded to hex, on a valid/ready handshake.
module seg7_capture #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic        clock,
   input  logic        n_reset,
   input  logic [6:0]  disp0,
   input  logic [6:0]  disp1,
   input  logic [6:0]  disp2,
   input  logic [6:0]  disp3,
   output logic [15:0] value,
   output logic [3:0]  blank,
   output logic [3:0]  illegal,
   output logic        value_valid,
   input  logic        value_ready
);

   typedef enum logic [1:0] {IDLE, SETTLE, PRESENT} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [27:0]      ALL_BLANK = {4{7'h7F}};

   // Returns {illegal, blank, nibble} for one active-low segment pattern.
   function automatic logic [5:0] decode(input logic [6:0] seg);
      case (seg)
         7'h40: decode = 6'h00;
         7'h79: decode = 6'h01;
         7'h24: decode = 6'h02;
         7'h30: decode = 6'h03;
         7'h19: decode = 6'h04;
         7'h12: decode = 6'h05;
         7'h02: decode = 6'h06;
         7'h78: decode = 6'h07;
         7'h00: decode = 6'h08;
         7'h10: decode = 6'h09;
         7'h08: decode = 6'h0A;
         7'h03: decode = 6'h0B;
         7'h46: decode = 6'h0C;
         7'h21: decode = 6'h0D;
         7'h06: decode = 6'h0E;
         7'h0E: decode = 6'h0F;
         7'h7F: decode = 6'b01_0000;
         default: decode = 6'b10_0000;
      endcase
   endfunction

   state_t           r_state, w_state_nxt;
   logic [27:0]      r_snap, r_rep;
   logic [CNT_W-1:0] r_cnt;
   logic [15:0]      r_value;
   logic [3:0]       r_blank, r_illegal;
   logic             r_valid;

   logic [27:0]      w_in;
   logic             w_same, w_load, w_hs;
   logic [5:0]       w_dec [4];

   assign w_in   = {disp3, disp2, disp1, disp0};
   assign w_same = (w_in == r_snap);
   assign w_hs   = (r_state == PRESENT) && r_valid && value_ready;

   for (genvar g = 0; g < 4; g++) begin : g_dec
      assign w_dec[g] = decode(r_snap[7*g +: 7]);
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_same) w_state_nxt = SETTLE;
         end
         SETTLE: begin
            if (w_same && (r_cnt == CNT_MAX)) begin
               if (r_snap != r_rep) begin
                  w_load      = 1'b1;
                  w_state_nxt = PRESENT;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         PRESENT: begin
            // A pattern arriving on the handshake edge must still be watched.
            if (w_hs) w_state_nxt = ((r_snap != r_rep) || !w_same) ? SETTLE : IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         r_state   <= IDLE;
         r_snap    <= ALL_BLANK;
         r_rep     <= ALL_BLANK;
         r_cnt     <= '0;
         r_value   <= '0;
         r_blank   <= '0;
         r_illegal <= '0;
         r_valid   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (!w_same) begin
            r_snap <= w_in;
            r_cnt  <= CNT_W'(1);
         end else if (r_cnt != CNT_MAX) begin
            r_cnt  <= r_cnt + CNT_W'(1);
         end
         if (w_load) begin
            r_value   <= {w_dec[3][3:0], w_dec[2][3:0], w_dec[1][3:0], w_dec[0][3:0]};
            r_blank   <= {w_dec[3][4], w_dec[2][4], w_dec[1][4], w_dec[0][4]};
            r_illegal <= {w_dec[3][5], w_dec[2][5], w_dec[1][5], w_dec[0][5]};
            r_rep     <= r_snap;
            r_valid   <= 1'b1;
         end else if (w_hs) begin
            r_valid   <= 1'b0;
         end
      end
   end

   assign value       = r_value;
   assign blank       = r_blank;
   assign illegal     = r_illegal;
   assign value_valid = r_valid;

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: directed display scenarios with literal expectations plus
// randomized display/ready traffic compared every cycle against a run-length model.
module tb_seg7_capture;
   localparam int S = 4;
   localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic        clock = 1'b0;
   logic        n_reset = 1'b0;
   logic [6:0]  disp0 = 7'h7F, disp1 = 7'h7F, disp2 = 7'h7F, disp3 = 7'h7F;
   logic        value_ready = 1'b1;
   logic [15:0] value;
   logic [3:0]  blank, illegal;
   logic        value_valid;

   int checks = 0;
   int failures = 0;
   int vcount = 0;

   seg7_capture #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
      .clock(clock), .n_reset(n_reset),
      .disp0(disp0), .disp1(disp1), .disp2(disp2), .disp3(disp3),
      .value(value), .blank(blank), .illegal(illegal),
      .value_valid(value_valid), .value_ready(value_ready)
   );

   always #5 clock = ~clock;

   // Reference model: run length of the current input, last reported pattern,
   // and two flags (a capture is on offer / the current run is being watched).
   logic [27:0] m_snap = {4{7'h7F}}, m_rep = {4{7'h7F}}, m_in;
   int          m_run = 0;
   bit          m_busy = 0, m_watch = 0, m_same;
   logic [15:0] m_value = '0;
   logic [3:0]  m_blank = '0, m_illegal = '0;

   function automatic logic [5:0] mdec(input logic [6:0] s);
      for (int i = 0; i < 16; i++) if (GLYPH[i] == s) return {2'b00, 4'(i)};
      if (s == 7'h7F) return 6'b01_0000;
      return 6'b10_0000;
   endfunction

   initial forever begin
      @(posedge clock or negedge n_reset);
      if (!n_reset) begin
         m_snap = {4{7'h7F}}; m_rep = {4{7'h7F}}; m_run = 0;
         m_busy = 0; m_watch = 0; m_value = '0; m_blank = '0; m_illegal = '0;
      end else begin
         m_in = {disp3, disp2, disp1, disp0};
         m_same = (m_in == m_snap);
         if (m_busy) begin
            if (value_ready) begin
               m_busy = 0;
               m_watch = (m_snap != m_rep) || !m_same;
            end
         end else if (m_watch) begin
            if (m_same && m_run >= S - 1) begin
               m_watch = 0;
               if (m_snap != m_rep) begin
                  m_busy = 1;
                  m_rep = m_snap;
                  for (int d = 0; d < 4; d++) begin
                     logic [5:0] r;
                     r = mdec(m_snap[7*d +: 7]);
                     m_value[4*d +: 4] = r[3:0];
                     m_blank[d] = r[4];
                     m_illegal[d] = r[5];
                  end
               end
            end
         end else if (!m_same) begin
            m_watch = 1;
         end
         m_run = m_same ? ((m_run < 1000) ? m_run + 1 : m_run) : 1;
         m_snap = m_in;
      end
   end

   // Every-cycle comparison against the model, sampled away from the active edge.
   always @(negedge clock) begin
      checks++;
      if ({value_valid, value, blank, illegal} !== {m_busy, m_value, m_blank, m_illegal}) begin
         failures++;
         $display("FAIL model t=%0t dut v=%b val=%h bl=%b il=%b, model v=%b val=%h bl=%b il=%b",
                  $time, value_valid, value, blank, illegal, m_busy, m_value, m_blank, m_illegal);
      end
   end

   always @(negedge clock) if (value_valid === 1'b1) vcount++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic set_disp(input logic [6:0] d3, input logic [6:0] d2,
                           input logic [6:0] d1, input logic [6:0] d0);
      disp3 = d3; disp2 = d2; disp1 = d1; disp0 = d0;
   endtask

   task automatic wait_valid(input string name, input int bound);
      int k;
      k = 0;
      while (value_valid !== 1'b1 && k < bound) begin
         @(negedge clock);
         k++;
      end
      checks++;
      if (value_valid !== 1'b1) begin
         failures++;
         $display("FAIL %s timeout got_valid=%b expected=1", name, value_valid);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout at t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      logic v [5];
      logic [15:0] v3;
      int first, vc0;

      // Reset and an all-blank display: never reported.
      #1;
      chk("reset_outputs", {15'd0, value_valid, value, blank, illegal}, 32'd0);
      step(2);
      n_reset = 1'b1;
      vc0 = vcount;
      step(50);
      chk("blank_no_report", vcount - vc0, 0);
      chk("blank_outputs_zero", {15'd0, value_valid, value, blank, illegal}, 32'd0);

      // 1234 with exact latency.
      set_disp(7'h79, 7'h24, 7'h30, 7'h19);
      for (int k = 0; k < 5; k++) begin
         @(posedge clock); #1;
         v[k] = value_valid;
         if (k == 3) v3 = value;
      end
      chk("lat_edge0_2", {v[0], v[1], v[2]}, 3'b000);
      chk("lat_edge3_valid", v[3], 1'b1);
      chk("lat_edge4_dropped", v[4], 1'b0);
      chk("value_1234", v3, 16'h1234);
      @(negedge clock);

      // Short glitch on digit 0 is filtered; a held one is reported.
      vc0 = vcount;
      disp0 = 7'h12; step(2);
      disp0 = 7'h19; step(10);
      chk("glitch_filtered", vcount - vc0, 0);
      disp0 = 7'h12;
      wait_valid("glitch_held", 10);
      chk("value_1235", value, 16'h1235);
      step(2);

      // Back-pressure: later pattern waits behind the held one.
      value_ready = 1'b0;
      set_disp(7'h08, 7'h03, 7'h46, 7'h21);
      wait_valid("abcd_valid", 10);
      chk("value_abcd", value, 16'hABCD);
      set_disp(7'h40, 7'h40, 7'h06, 7'h0E);
      step(10);
      chk("held_abcd", {value_valid, value}, {1'b1, 16'hABCD});
      value_ready = 1'b1;
      step(1);
      chk("abcd_accepted", value_valid, 1'b0);
      step(1);
      chk("value_00ef", {value_valid, value}, {1'b1, 16'h00EF});
      step(2);

      // Blank and illegal digits.
      set_disp(7'h40, 7'h7F, 7'h7E, 7'h40);
      wait_valid("blank_illegal_valid", 10);
      chk("bi_value", value, 16'h0000);
      chk("bi_blank", blank, 4'b0100);
      chk("bi_illegal", illegal, 4'b0010);
      step(2);

      // Asynchronous reset while presenting, then re-report.
      value_ready = 1'b0;
      set_disp(7'h79, 7'h24, 7'h30, 7'h19);
      wait_valid("pre_reset_valid", 10);
      step(2);
      #2 n_reset = 1'b0;
      #1 chk("async_reset_drop", {value_valid, value}, 17'd0);
      step(2);
      n_reset = 1'b1;
      first = 0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clock); #1;
         if (value_valid === 1'b1 && first == 0) first = k;
      end
      chk("rereport_edge", first, S);
      chk("rereport_value", value, 16'h1234);
      @(negedge clock);
      value_ready = 1'b1;
      step(3);

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clock);
         value_ready = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 5) == 0) begin
            int sel;
            logic [6:0] p;
            sel = $urandom_range(0, 17);
            p = (sel < 16) ? GLYPH[sel] : (sel == 16) ? 7'h7F : 7'($urandom);
            case ($urandom_range(0, 3))
               0: disp0 = p;
               1: disp1 = p;
               2: disp2 = p;
               default: disp3 = p;
            endcase
         end
      end
      step(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
